// File: rtl/dmem_responder_pkg.sv
// Shared constants and types for the data-memory responder.
package dmem_responder_pkg;

    localparam int unsigned DMEM_ADDR_BITS = 32;
    localparam int unsigned DMEM_LINE_BITS = 128;
    localparam int unsigned DMEM_LINES     = 4096;
    localparam int unsigned DMEM_LATENCY   = 5;
    localparam int unsigned LINE_OFF_BITS  = $clog2(DMEM_LINE_BITS / 8);
    localparam int unsigned DMEM_IDX_BITS  = $clog2(DMEM_LINES);

    typedef logic [1:0] dmem_state_t;

    localparam dmem_state_t ST_IDLE = 2'd0;
    localparam dmem_state_t ST_WAIT = 2'd1;
    localparam dmem_state_t ST_RESP = 2'd2;
    localparam dmem_state_t ST_GAP  = 2'd3;

    // Request captured at acceptance; the bus is ignored until completion.
    typedef struct packed {
        logic                      we;
        logic [DMEM_IDX_BITS-1:0]  idx;
        logic [DMEM_LINE_BITS-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Cache-to-memory request/response bus.
interface dmem_responder_if
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DMEM_ADDR_BITS,
    parameter int unsigned LINE_BITS = DMEM_LINE_BITS
);
    logic                 req_valid;
    logic                 req_we;
    logic [ADDR_BITS-1:0] req_addr;
    logic [LINE_BITS-1:0] req_wdata;
    logic                 req_ready;
    logic                 resp_valid;
    logic [LINE_BITS-1:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/dmem_responder_array.sv
// Single-port line-wide backing store; rdata holds a line only the cycle after a read.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter  int unsigned LINE_BITS = DMEM_LINE_BITS,
    parameter  int unsigned MEM_LINES = DMEM_LINES,
    localparam int unsigned IDX_BITS  = $clog2(MEM_LINES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic                 re,
    input  logic [IDX_BITS-1:0]  idx,
    input  logic [LINE_BITS-1:0] wdata,
    output logic [LINE_BITS-1:0] rdata
);
    logic [LINE_BITS-1:0] mem [MEM_LINES];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    // Output register clears when not reading so the bus sees zero outside read responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    rdata <= '0;
        else if (re) rdata <= mem[idx];
        else         rdata <= '0;
    end
endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency main-memory responder for L1 D-cache fills and write-backs.
// Optional perf_reads/perf_writes counters when DMEM_PERF_EN is defined.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DMEM_ADDR_BITS,
    parameter int unsigned LINE_BITS = DMEM_LINE_BITS,
    parameter int unsigned MEM_LINES = DMEM_LINES,
    parameter int unsigned LATENCY   = DMEM_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
`ifdef DMEM_PERF_EN
    ,
    output logic [31:0]       perf_reads,
    output logic [31:0]       perf_writes
`endif
);
    localparam int unsigned OFF_BITS = $clog2(LINE_BITS / 8);
    localparam int unsigned IDX_BITS = $clog2(MEM_LINES);
    localparam int unsigned CNT_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dmem_state_t          state, state_nx;
    logic [CNT_BITS-1:0]  cnt, cnt_nx;
    dmem_req_t            req_q, req_nx;
    logic                 rd_en, wr_en;
    logic [ADDR_BITS-1:0] req_addr;
    logic [IDX_BITS-1:0]  in_idx, arr_idx;

    // High address bits wrap modulo the store size.
    assign req_addr = bus.req_addr;
    assign in_idx   = IDX_BITS'(req_addr >> OFF_BITS);
    assign arr_idx  = (state == ST_IDLE) ? in_idx : IDX_BITS'(req_q.idx);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        req_nx   = req_q;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    req_nx.we    = bus.req_we;
                    req_nx.idx   = DMEM_IDX_BITS'(in_idx);
                    req_nx.wdata = DMEM_LINE_BITS'(bus.req_wdata);
                    cnt_nx       = CNT_BITS'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_nx = ST_RESP;
                        rd_en    = !bus.req_we;
                    end else begin
                        state_nx = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_nx = cnt - CNT_BITS'(1);
                // Read is launched on the edge entering RESP so data lines up with resp_valid.
                if (cnt == CNT_BITS'(1)) begin
                    state_nx = ST_RESP;
                    rd_en    = !req_q.we;
                end
            end
            ST_RESP: begin
                wr_en    = req_q.we;
                state_nx = ST_GAP;
            end
            ST_GAP:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            req_q          <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            req_q          <= req_nx;
            bus.req_ready  <= (state_nx == ST_IDLE);
            bus.resp_valid <= (state_nx == ST_RESP);
        end
    end

    dmem_array #(
        .LINE_BITS (LINE_BITS),
        .MEM_LINES (MEM_LINES)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .re    (rd_en),
        .idx   (arr_idx),
        .wdata (LINE_BITS'(req_q.wdata)),
        .rdata (bus.resp_rdata)
    );

`ifdef DMEM_PERF_EN
    // Saturating completion counters, bumped once per RESP cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_reads  <= '0;
            perf_writes <= '0;
        end else if (state == ST_RESP) begin
            if (req_q.we) begin
                if (perf_writes != 32'hFFFF_FFFF) perf_writes <= perf_writes + 32'd1;
            end else begin
                if (perf_reads != 32'hFFFF_FFFF) perf_reads <= perf_reads + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=5 and LATENCY=1 instances).
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if #(.ADDR_BITS(32), .LINE_BITS(128)) bus0 ();
    dmem_responder_if #(.ADDR_BITS(32), .LINE_BITS(128)) bus1 ();

`ifdef DMEM_PERF_EN
    logic [31:0] perf_reads0, perf_writes0, perf_reads1, perf_writes1;
`endif

    dmem_responder #(.ADDR_BITS(32), .LINE_BITS(128), .MEM_LINES(4096), .LATENCY(5)) u_dut (
        .clk (clk), .rst (rst), .bus (bus0)
`ifdef DMEM_PERF_EN
        , .perf_reads (perf_reads0), .perf_writes (perf_writes0)
`endif
    );

    dmem_responder #(.ADDR_BITS(32), .LINE_BITS(128), .MEM_LINES(4096), .LATENCY(1)) u_dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
`ifdef DMEM_PERF_EN
        , .perf_reads (perf_reads1), .perf_writes (perf_writes1)
`endif
    );

    localparam logic [127:0] D1  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] DAA = {16{8'hAA}};
    localparam logic [127:0] D55 = {16{8'h55}};
    localparam logic [127:0] DFF = {16{8'hFF}};
    localparam logic [127:0] D2  = 128'hDEADBEEF_CAFEF00D_13579BDF_2468ACE0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? bus0.req_ready : bus1.req_ready;
    endfunction

    function automatic logic rv(input int sel);
        return (sel == 0) ? bus0.resp_valid : bus1.resp_valid;
    endfunction

    function automatic logic [127:0] rd(input int sel);
        return (sel == 0) ? bus0.resp_rdata : bus1.resp_rdata;
    endfunction

    task automatic drive(input int sel, input logic v, input logic we,
                         input logic [31:0] a, input logic [127:0] d);
        if (sel == 0) begin
            bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = a; bus0.req_wdata = d;
        end else begin
            bus1.req_valid = v; bus1.req_we = we; bus1.req_addr = a; bus1.req_wdata = d;
        end
    endtask

    task automatic wait_ready(input int sel);
        int n = 0;
        while (!rdy(sel) && n < 50) begin tick(); n++; end
        if (n >= 50) check("ready_timeout", 128'(rdy(sel)), 128'd1);
    endtask

    // Issue one request, hold it until resp_valid, then release; lat counts edges from acceptance.
    task automatic do_req(input int sel, input logic we, input logic [31:0] a, input logic [127:0] d,
                          output logic [127:0] rdata, output int lat, output logic saw_ready);
        wait_ready(sel);
        drive(sel, 1'b1, we, a, d);
        lat = 0;
        saw_ready = 1'b0;
        do begin
            tick();
            lat++;
            if (!rv(sel) && rdy(sel)) saw_ready = 1'b1;
        end while (!rv(sel) && lat < 50);
        rdata = rd(sel);
        drive(sel, 1'b0, 1'b0, 32'h0, 128'h0);
    endtask

    initial begin
        logic [127:0] r;
        int lat, pulses, second;
        logic sr;

        drive(0, 1'b0, 1'b0, 32'h0, 128'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 128'h0);

        // Reset and idle
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("rst_ready",  128'(bus0.req_ready), 128'd1);
        check("rst_resp",   128'(bus0.resp_valid), 128'd0);
        check("rst_rdata",  bus0.resp_rdata, 128'd0);
        check("rst_ready1", 128'(bus1.req_ready), 128'd1);
        pulses = 0;
        repeat (20) begin tick(); if (bus0.resp_valid) pulses++; end
        check("idle_no_resp", 128'(pulses), 128'd0);

        // Write then read back the same line with a different offset
        do_req(0, 1'b1, 32'h0000_0040, D1, r, lat, sr);
        check("wr_lat",        128'(lat), 128'd5);
        check("wr_rdata",      r, 128'd0);
        check("wr_busy_ready", 128'(sr), 128'd0);
        check("wr_resp_ready", 128'(bus0.req_ready), 128'd0);
        tick();
        check("gap_ready", 128'(bus0.req_ready), 128'd0);
        check("gap_resp",  128'(bus0.resp_valid), 128'd0);
        tick();
        check("post_gap_ready", 128'(bus0.req_ready), 128'd1);
        do_req(0, 1'b0, 32'h0000_004C, 128'h0, r, lat, sr);
        check("rd_lat",  128'(lat), 128'd5);
        check("rd_data", r, D1);

        // Address wrap-around onto line 0
        do_req(0, 1'b1, 32'h0001_0000, DAA, r, lat, sr);
        do_req(0, 1'b0, 32'h0000_0000, 128'h0, r, lat, sr);
        check("wrap_data", r, DAA);

        // Held request: second acceptance only after GAP
        wait_ready(0);
        drive(0, 1'b1, 1'b0, 32'h0000_0040, 128'h0);
        tick();
        second = -1;
        pulses = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (bus0.resp_valid) pulses++;
            if (second < 0 && bus0.req_ready) second = k + 1;
        end
        drive(0, 1'b0, 1'b0, 32'h0, 128'h0);
        check("held_second_edge", 128'(second), 128'd7);
        check("held_pulses",      128'(pulses), 128'd1);
        lat = 0;
        do begin tick(); lat++; end while (!bus0.resp_valid && lat < 50);
        check("held2_lat",  128'(lat), 128'd4);
        check("held2_data", bus0.resp_rdata, D1);

        // Reset in the second WAIT cycle aborts the write
        do_req(0, 1'b1, 32'h0000_0080, D55, r, lat, sr);
        wait_ready(0);
        drive(0, 1'b1, 1'b1, 32'h0000_0080, DFF);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rstmid_resp",  128'(bus0.resp_valid), 128'd0);
        check("rstmid_ready", 128'(bus0.req_ready), 128'd1);
        drive(0, 1'b0, 1'b0, 32'h0, 128'h0);
        tick();
        tick();
        rst = 1'b1;
        pulses = 0;
        repeat (8) begin tick(); if (bus0.resp_valid) pulses++; end
        check("rstmid_no_resp", 128'(pulses), 128'd0);
        do_req(0, 1'b0, 32'h0000_0080, 128'h0, r, lat, sr);
        check("rstmid_old_data", r, D55);

        // LATENCY=1 instance
        do_req(1, 1'b1, 32'h0000_0020, D2, r, lat, sr);
        check("l1_wr_lat",   128'(lat), 128'd1);
        check("l1_wr_rdata", r, 128'd0);
        do_req(1, 1'b0, 32'h0000_0020, 128'h0, r, lat, sr);
        check("l1_rd_lat",  128'(lat), 128'd1);
        check("l1_rd_data", r, D2);

`ifdef DMEM_PERF_EN
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("perf_rst_reads",  128'(perf_reads0), 128'd0);
        check("perf_rst_writes", 128'(perf_writes0), 128'd0);
        do_req(0, 1'b0, 32'h0000_0000, 128'h0, r, lat, sr);
        do_req(0, 1'b1, 32'h0000_0100, D1, r, lat, sr);
        do_req(0, 1'b0, 32'h0000_0100, 128'h0, r, lat, sr);
        do_req(0, 1'b1, 32'h0000_0110, D2, r, lat, sr);
        do_req(0, 1'b0, 32'h0000_0110, 128'h0, r, lat, sr);
        tick();
        check("perf_reads",  128'(perf_reads0), 128'd3);
        check("perf_writes", 128'(perf_writes0), 128'd2);
        rst = 1'b0;
        #1;
        check("perf_clr_reads",  128'(perf_reads0), 128'd0);
        check("perf_clr_writes", 128'(perf_writes0), 128'd0);
        rst = 1'b1;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
